// File: rtl/sign_narrower.sv
// ----------------------------------------------------------------------------
// sign_narrower
//
// Narrows signed two's-complement samples from INPUT_DATA_SIZE bits down to
// OUTPUT_DATA_SIZE bits. Values outside the output range are clamped to the
// nearest representable value. This is the inverse of the sign-extension
// path and feeds the 14-bit DAC side of the gain-control datapath.
//
// The block is a single registered stage with valid/ready handshakes on both
// sides. It can accept a new sample every cycle while downstream is ready.
// It also counts clamp events so firmware can detect gain overshoot.
//
// Parameters
//   INPUT_DATA_SIZE   width of the signed input sample (must exceed output)
//   OUTPUT_DATA_SIZE  width of the signed output sample
//   SAT_COUNT_SIZE    width of the saturation event counter
//
// Ports
//   clock            system clock, rising edge
//   resetN           asynchronous active-low reset
//   inputData        signed input sample
//   inputValid       inputData is valid
//   inputReady       stage accepts inputData this cycle
//   outputData       signed narrowed sample
//   outputValid      outputData is valid
//   outputReady      downstream accepts outputData
//   outputSaturated  outputData was clamped (travels with outputData)
//   saturationCount  number of accepted samples that were clamped
//   overflowSticky   set on any clamp, cleared only by clearCount
//   clearCount       synchronous clear of saturationCount / overflowSticky
// ----------------------------------------------------------------------------
module sign_narrower #(
    parameter int INPUT_DATA_SIZE  = 16,
    parameter int OUTPUT_DATA_SIZE = 14,
    parameter int SAT_COUNT_SIZE   = 16
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic [INPUT_DATA_SIZE-1:0]  inputData,
    input  logic                        inputValid,
    output logic                        inputReady,
    output logic [OUTPUT_DATA_SIZE-1:0] outputData,
    output logic                        outputValid,
    input  logic                        outputReady,
    output logic                        outputSaturated,
    output logic [SAT_COUNT_SIZE-1:0]   saturationCount,
    output logic                        overflowSticky,
    input  logic                        clearCount
);

    // Number of top input bits that must agree for the value to fit: every
    // dropped bit plus the new sign bit.
    localparam int HEAD_SIZE = INPUT_DATA_SIZE - OUTPUT_DATA_SIZE + 1;

    localparam logic [OUTPUT_DATA_SIZE-1:0] MAX_VALUE = {1'b0, {(OUTPUT_DATA_SIZE-1){1'b1}}};
    localparam logic [OUTPUT_DATA_SIZE-1:0] MIN_VALUE = {1'b1, {(OUTPUT_DATA_SIZE-1){1'b0}}};
    localparam logic [SAT_COUNT_SIZE-1:0]   COUNT_FULL = {SAT_COUNT_SIZE{1'b1}};
    localparam logic [SAT_COUNT_SIZE-1:0]   COUNT_ONE  = {{(SAT_COUNT_SIZE-1){1'b0}}, 1'b1};

    logic [HEAD_SIZE-1:0]        head_bits;
    logic                        in_range;
    logic                        input_sign;
    logic [OUTPUT_DATA_SIZE-1:0] narrowed_data;
    logic                        narrowed_sat;
    logic                        accept;
    logic                        clamp_accept;

    assign head_bits  = inputData[INPUT_DATA_SIZE-1 -: HEAD_SIZE];
    assign input_sign = inputData[INPUT_DATA_SIZE-1];

    // All-zero or all-one head means the discarded bits are pure sign copies.
    assign in_range = (&head_bits) | ~(|head_bits);

    // The sign of the wide input tells which rail an out-of-range value hits.
    always_comb begin
        narrowed_data = inputData[OUTPUT_DATA_SIZE-1:0];
        narrowed_sat  = 1'b0;
        if (!in_range) begin
            narrowed_sat  = 1'b1;
            narrowed_data = input_sign ? MIN_VALUE : MAX_VALUE;
        end
    end

    // The register can take a new sample whenever it is empty or is being
    // emptied this very cycle, giving one sample per clock at full rate.
    assign inputReady   = !outputValid || outputReady;
    assign accept       = inputValid && inputReady;
    assign clamp_accept = accept && narrowed_sat;

    // Output register: load on accept, drop valid once the held sample has
    // been taken and nothing replaces it, otherwise hold.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            outputData      <= '0;
            outputSaturated <= 1'b0;
            outputValid     <= 1'b0;
        end else if (accept) begin
            outputData      <= narrowed_data;
            outputSaturated <= narrowed_sat;
            outputValid     <= 1'b1;
        end else if (outputReady) begin
            outputValid     <= 1'b0;
        end
    end

    // Clamp statistics. A clear wipes the old value but still records a
    // clamp accepted in the same cycle, so no event is lost across a clear.
    // The counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            saturationCount <= '0;
            overflowSticky  <= 1'b0;
        end else if (clearCount) begin
            saturationCount <= clamp_accept ? COUNT_ONE : '0;
            overflowSticky  <= clamp_accept;
        end else if (clamp_accept) begin
            if (saturationCount != COUNT_FULL) begin
                saturationCount <= saturationCount + COUNT_ONE;
            end
            overflowSticky  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sign_narrower.sv
// ----------------------------------------------------------------------------
// tb_sign_narrower
//
// Self-checking bench for sign_narrower with the default 16 -> 14 bit sizes.
// Each accepted sample pushes its expected narrowed value onto a scoreboard
// queue; a monitor pops and compares whenever the DUT hands a sample over.
// A table of vectors covers the narrowing rules, followed by hand-written
// sequences for stalls, counter saturation, clear priority and reset.
// ----------------------------------------------------------------------------
module tb_sign_narrower;

    localparam int IN_W  = 16;
    localparam int OUT_W = 14;
    localparam int CNT_W = 16;

    logic              clock;
    logic              resetN;
    logic [IN_W-1:0]   inputData;
    logic              inputValid;
    logic              inputReady;
    logic [OUT_W-1:0]  outputData;
    logic              outputValid;
    logic              outputReady;
    logic              outputSaturated;
    logic [CNT_W-1:0]  saturationCount;
    logic              overflowSticky;
    logic              clearCount;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sat;
    } expect_t;

    typedef struct {
        logic [IN_W-1:0]  in_data;
        logic [OUT_W-1:0] exp_data;
        logic             exp_sat;
    } vector_t;

    expect_t sb[$];
    vector_t vectors[11];

    int checks;
    int failures;
    logic random_ready;

    sign_narrower #(
        .INPUT_DATA_SIZE (IN_W),
        .OUTPUT_DATA_SIZE(OUT_W),
        .SAT_COUNT_SIZE  (CNT_W)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .inputData      (inputData),
        .inputValid     (inputValid),
        .inputReady     (inputReady),
        .outputData     (outputData),
        .outputValid    (outputValid),
        .outputReady    (outputReady),
        .outputSaturated(outputSaturated),
        .saturationCount(saturationCount),
        .overflowSticky (overflowSticky),
        .clearCount     (clearCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent reference: compare as signed integers against the rails.
    function automatic expect_t refNarrow(input logic [IN_W-1:0] x);
        expect_t r;
        int v;
        v = int'($signed(x));
        if (v > 8191) begin
            r.data = 14'h1FFF;
            r.sat  = 1'b1;
        end else if (v < -8192) begin
            r.data = 14'h2000;
            r.sat  = 1'b1;
        end else begin
            r.data = OUT_W'(v);
            r.sat  = 1'b0;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one sample, wait (bounded) for it to be taken, record the
    // expectation and return one step after the accepting edge.
    task automatic applyStimulus(input logic [IN_W-1:0] data,
                                 input logic [OUT_W-1:0] exp_data,
                                 input logic exp_sat);
        bit taken;
        expect_t e;
        taken      = 1'b0;
        inputData  = data;
        inputValid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (inputReady) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got inputReady=0, expected 1 within 200 cycles");
            inputValid = 1'b0;
            return;
        end
        e.data = exp_data;
        e.sat  = exp_sat;
        sb.push_back(e);
        @(posedge clock);
        #1;
        inputValid = 1'b0;
    endtask

    // Scoreboard side: every handover must match the oldest expectation.
    always @(negedge clock) begin
        expect_t e;
        if (resetN && outputValid && outputReady) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got 0x%0h, expected no sample", outputData);
            end else begin
                e = sb.pop_front();
                checkOutput("outputData", 32'(outputData), 32'(e.data));
                checkOutput("outputSaturated", 32'(outputSaturated), 32'(e.sat));
            end
        end
    end

    // Random backpressure while random_ready is set.
    always @(posedge clock) begin
        if (random_ready) begin
            #1;
            outputReady = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        expect_t r;
        logic [IN_W-1:0] rnd;
        bit drained;

        vectors[0]  = '{16'h0FFF, 14'h0FFF, 1'b0};
        vectors[1]  = '{16'hF000, 14'h3000, 1'b0};
        vectors[2]  = '{16'h0000, 14'h0000, 1'b0};
        vectors[3]  = '{16'h2000, 14'h1FFF, 1'b1};
        vectors[4]  = '{16'h8000, 14'h2000, 1'b1};
        vectors[5]  = '{16'h1FFF, 14'h1FFF, 1'b0};
        vectors[6]  = '{16'hE000, 14'h2000, 1'b0};
        vectors[7]  = '{16'hDFFF, 14'h2000, 1'b1};
        vectors[8]  = '{16'h7FFF, 14'h1FFF, 1'b1};
        vectors[9]  = '{16'hFFFF, 14'h3FFF, 1'b0};
        vectors[10] = '{16'h0001, 14'h0001, 1'b0};

        checks       = 0;
        failures     = 0;
        random_ready = 1'b0;
        resetN       = 1'b0;
        inputData    = '0;
        inputValid   = 1'b0;
        outputReady  = 1'b1;
        clearCount   = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_outputValid", 32'(outputValid), 32'd0);
        checkOutput("reset_outputData", 32'(outputData), 32'd0);
        checkOutput("reset_saturationCount", 32'(saturationCount), 32'd0);
        checkOutput("reset_overflowSticky", 32'(overflowSticky), 32'd0);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("reset_inputReady", 32'(inputReady), 32'd1);

        $display("[TB] table vectors");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vectors[i].in_data, vectors[i].exp_data, vectors[i].exp_sat);
            if (i == 0) begin
                checkOutput("latency_outputValid", 32'(outputValid), 32'd1);
                checkOutput("latency_outputData", 32'(outputData), 32'h0FFF);
            end
            if (i == 2) begin
                checkOutput("inrange_count", 32'(saturationCount), 32'd0);
                checkOutput("inrange_sticky", 32'(overflowSticky), 32'd0);
            end
            if (i == 4) begin
                checkOutput("clamp_count", 32'(saturationCount), 32'd2);
                checkOutput("clamp_sticky", 32'(overflowSticky), 32'd1);
            end
        end
        checkOutput("table_count", 32'(saturationCount), 32'd4);

        $display("[TB] stall sequence");
        applyStimulus(16'h0123, 14'h0123, 1'b0);
        applyStimulus(16'hC000, 14'h2000, 1'b1);
        outputReady = 1'b0;
        inputData   = 16'h1000;
        inputValid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput("stall_inputReady", 32'(inputReady), 32'd0);
            checkOutput("stall_outputValid", 32'(outputValid), 32'd1);
            checkOutput("stall_outputData", 32'(outputData), 32'h2000);
        end
        @(posedge clock);
        #1;
        outputReady = 1'b1;
        applyStimulus(16'h1000, 14'h1000, 1'b0);
        applyStimulus(16'hFFF0, 14'h3FF0, 1'b0);

        $display("[TB] random stream with backpressure");
        random_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rnd = IN_W'($urandom_range(0, 65535));
            r   = refNarrow(rnd);
            applyStimulus(rnd, r.data, r.sat);
        end
        random_ready = 1'b0;
        @(posedge clock);
        #2;
        outputReady = 1'b1;

        $display("[TB] counter saturation");
        clearCount = 1'b1;
        @(posedge clock);
        #1;
        clearCount = 1'b0;
        checkOutput("cleared_count", 32'(saturationCount), 32'd0);
        for (int i = 0; i < 65534; i++) begin
            applyStimulus(16'h4000, 14'h1FFF, 1'b1);
        end
        checkOutput("count_fffe", 32'(saturationCount), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'hA000, 14'h2000, 1'b1);
            checkOutput("count_hold", 32'(saturationCount), 32'hFFFF);
        end

        $display("[TB] clear priority");
        clearCount = 1'b1;
        applyStimulus(16'h7FFF, 14'h1FFF, 1'b1);
        clearCount = 1'b0;
        checkOutput("clear_clamp_count", 32'(saturationCount), 32'd1);
        checkOutput("clear_clamp_sticky", 32'(overflowSticky), 32'd1);
        clearCount = 1'b1;
        @(posedge clock);
        #1;
        clearCount = 1'b0;
        checkOutput("clear_only_count", 32'(saturationCount), 32'd0);
        checkOutput("clear_only_sticky", 32'(overflowSticky), 32'd0);

        $display("[TB] reset while holding");
        repeat (3) @(posedge clock);
        #1;
        outputReady = 1'b0;
        applyStimulus(16'h8000, 14'h2000, 1'b1);
        checkOutput("hold_outputValid", 32'(outputValid), 32'd1);
        checkOutput("hold_count", 32'(saturationCount), 32'd1);
        #3;
        resetN = 1'b0;
        #1;
        sb.delete();
        checkOutput("midreset_outputValid", 32'(outputValid), 32'd0);
        checkOutput("midreset_outputData", 32'(outputData), 32'd0);
        checkOutput("midreset_outputSaturated", 32'(outputSaturated), 32'd0);
        checkOutput("midreset_count", 32'(saturationCount), 32'd0);
        checkOutput("midreset_sticky", 32'(overflowSticky), 32'd0);
        @(posedge clock);
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("postreset_inputReady", 32'(inputReady), 32'd1);
        checkOutput("postreset_outputValid", 32'(outputValid), 32'd0);
        outputReady = 1'b1;
        applyStimulus(16'h0005, 14'h0005, 1'b0);

        drained = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clock);
            if (sb.size() == 0 && !outputValid) begin
                drained = 1'b1;
                break;
            end
        end
        checkOutput("scoreboard_drained", 32'(drained), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
